imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/imm_decode_stage_if.sv | 27 ++
 rtl/imm_extract.sv | 103 ++++++++++
 rtl/imm_decode_stage.sv | 124 ++++++++++++
 tb/tb_imm_decode_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: opcodes, funct3 values and the immediate-format encoding.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6
  } imm_fmt_e;

  // Shift-immediate instructions are identified by funct3 alone.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream instruction handshake plus downstream decoded-immediate handshake.
interface imm_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  import riscv_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_imm;
  imm_fmt_e           out_fmt;
  logic               out_illegal;
  logic [XLEN-1:0]    out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
  );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extractor: format, sign/zero-extended immediate and legality for XLEN.
module imm_extract
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    imm,
  output imm_fmt_e           fmt,
  output logic               illegal
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;

  // Raw field slices; signed types make the XLEN'() casts below sign-extend.
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = is_shift_f3(funct3);
  assign i_imm    = instr[31:20];
  assign s_imm    = {instr[31:25], instr[11:7]};
  assign b_imm    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm    = {instr[31:12], 12'b0};
  assign j_imm    = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode-driven format select; unknown opcodes are illegal only if not a 32-bit encoding.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = (instr[1:0] != 2'b11);
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm     = XLEN'(i_imm);
        fmt     = FMT_I;
        illegal = 1'b0;
      end
      OPC_OP_IMM: begin
        illegal = 1'b0;
        if (is_shift) begin
          fmt = FMT_SHAMT;
          if (IS_RV64) begin
            imm = XLEN'(instr[25:20]);
          end else begin
            imm     = XLEN'(instr[24:20]);
            illegal = instr[25];
          end
        end else begin
          imm = XLEN'(i_imm);
          fmt = FMT_I;
        end
      end
      OPC_OP_IMM_32: begin
        // Word ops exist only on RV64 and always use a 5-bit shift amount.
        if (IS_RV64) begin
          illegal = 1'b0;
          if (is_shift) begin
            imm     = XLEN'(instr[24:20]);
            fmt     = FMT_SHAMT;
            illegal = instr[25];
          end else begin
            imm = XLEN'(i_imm);
            fmt = FMT_I;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        imm     = XLEN'(s_imm);
        fmt     = FMT_S;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        imm     = XLEN'(b_imm);
        fmt     = FMT_B;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm     = XLEN'(u_imm);
        fmt     = FMT_U;
        illegal = 1'b0;
      end
      OPC_JAL: begin
        imm     = XLEN'(j_imm);
        fmt     = FMT_J;
        illegal = 1'b0;
      end
      default: begin
        imm = '0;
        fmt = FMT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// One-cycle immediate decode stage with optional one-entry skid buffer and synchronous flush.
// XLEN must be 32 or 64 and must match the XLEN of the connected interface.
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          SKID = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_decode_stage_if.slave bus
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  logic            out_valid_q,   out_valid_d;
  logic [XLEN-1:0] out_imm_q,     out_imm_d;
  imm_fmt_e        out_fmt_q,     out_fmt_d;
  logic            out_illegal_q, out_illegal_d;
  logic [XLEN-1:0] out_pc_q,      out_pc_d;

  logic            skid_full_q,    skid_full_d;
  logic [XLEN-1:0] skid_imm_q,     skid_imm_d;
  imm_fmt_e        skid_fmt_q,     skid_fmt_d;
  logic            skid_illegal_q, skid_illegal_d;
  logic [XLEN-1:0] skid_pc_q,      skid_pc_d;

  logic in_ready_c;
  logic in_fire;
  logic out_fire;

  imm_extract #(.XLEN(XLEN)) u_imm_extract (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Skid variant: ready is a flop; pass-through variant: ready follows the output side.
  assign in_ready_c = SKID ? !skid_full_q : (bus.out_ready || !out_valid_q);
  assign in_fire    = bus.in_valid && in_ready_c;
  assign out_fire   = out_valid_q && bus.out_ready;

  // Next-state: flush wins; a free output slot refills from skid first to keep order.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_illegal_d  = out_illegal_q;
    out_pc_d       = out_pc_q;
    skid_full_d    = skid_full_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_illegal_d = skid_illegal_q;
    skid_pc_d      = skid_pc_q;

    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (out_fire || !out_valid_q) begin
      if (skid_full_q) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_illegal_q;
        out_pc_d      = skid_pc_q;
        skid_full_d   = 1'b0;
      end else if (in_fire) begin
        out_valid_d   = 1'b1;
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_illegal;
        out_pc_d      = bus.in_pc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled: park the new result (only reachable with the skid enabled).
      skid_full_d    = 1'b1;
      skid_imm_d     = dec_imm;
      skid_fmt_d     = dec_fmt;
      skid_illegal_d = dec_illegal;
      skid_pc_d      = bus.in_pc;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      out_pc_q       <= '0;
      skid_full_q    <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
      skid_pc_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_illegal_q  <= out_illegal_d;
      out_pc_q       <= out_pc_d;
      skid_full_q    <= skid_full_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_illegal_q <= skid_illegal_d;
      skid_pc_q      <= skid_pc_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_pc      = out_pc_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench: RV32/RV64 skid instances share stimulus; an RV32 no-skid instance checks ready.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  int n_applied = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) bus32 ();
  imm_decode_stage_if #(.XLEN(64)) bus64 ();
  imm_decode_stage_if #(.XLEN(32)) bus_s0 ();

  assign bus32.in_valid   = in_valid;
  assign bus32.in_instr   = in_instr;
  assign bus32.in_pc      = in_pc[31:0];
  assign bus32.out_ready  = out_ready;
  assign bus64.in_valid   = in_valid;
  assign bus64.in_instr   = in_instr;
  assign bus64.in_pc      = in_pc;
  assign bus64.out_ready  = out_ready;
  assign bus_s0.in_valid  = in_valid;
  assign bus_s0.in_instr  = in_instr;
  assign bus_s0.in_pc     = in_pc[31:0];
  assign bus_s0.out_ready = out_ready;

  imm_decode_stage #(.XLEN(32), .SKID(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
  imm_decode_stage #(.XLEN(64), .SKID(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));
  imm_decode_stage #(.XLEN(32), .SKID(1'b0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_s0));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32;
    logic [2:0]  fmt64;
    logic        ill32;
    logic        ill64;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         instr         imm32                  imm64                  f32   f64   i32   i64
    vecs[0]  = '{32'hFFF00093, 64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{32'h03F01093, 64'h000000000000001F, 64'h000000000000003F, 3'd2, 3'd2, 1'b1, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 64'h00000000FFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd4, 3'd4, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000006F, 64'h0000000000000000, 64'h0000000000000000, 3'd6, 3'd6, 1'b0, 1'b0};
    vecs[4]  = '{32'hFE112C23, 64'h00000000FFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 3'd3, 1'b0, 1'b0};
    vecs[5]  = '{32'h800000B7, 64'h0000000080000000, 64'hFFFFFFFF80000000, 3'd5, 3'd5, 1'b0, 1'b0};
    vecs[6]  = '{32'h12345097, 64'h0000000012345000, 64'h0000000012345000, 3'd5, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{32'h7FF02083, 64'h00000000000007FF, 64'h00000000000007FF, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[8]  = '{32'h0010009B, 64'h0000000000000000, 64'h0000000000000001, 3'd0, 3'd1, 1'b1, 1'b0};
    vecs[9]  = '{32'h00000033, 64'h0000000000000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{32'h00000001, 64'h0000000000000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{32'h800000E7, 64'h00000000FFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[12] = '{32'h4050D093, 64'h0000000000000005, 64'h0000000000000005, 3'd2, 3'd2, 1'b0, 1'b0};
    vecs[13] = '{32'hFFFFF06F, 64'h00000000FFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd6, 3'd6, 1'b0, 1'b0};

    // Reset state, sampled before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst out_valid32", 64'(bus32.out_valid), 64'd0);
    check("rst out_valid64", 64'(bus64.out_valid), 64'd0);
    check("rst in_ready32", 64'(bus32.in_ready), 64'd1);
    check("rst out_imm64", 64'(bus64.out_imm), 64'd0);
    check("rst out_pc64", 64'(bus64.out_pc), 64'd0);
    check("rst out_fmt32", 64'(bus32.out_fmt), 64'd0);
    check("rst out_illegal32", 64'(bus32.out_illegal), 64'd0);
    step();
    step();
    check("rst held out_valid32", 64'(bus32.out_valid), 64'd0);
    rst_n = 1'b1;

    // Back-to-back table vectors: each result must appear one edge after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 64'h1000 + 64'(4 * i);
      step();
      check($sformatf("v%0d valid32", i), 64'(bus32.out_valid), 64'd1);
      check($sformatf("v%0d imm32", i), 64'(bus32.out_imm), vecs[i].imm32);
      check($sformatf("v%0d fmt32", i), 64'(bus32.out_fmt), 64'(vecs[i].fmt32));
      check($sformatf("v%0d ill32", i), 64'(bus32.out_illegal), 64'(vecs[i].ill32));
      check($sformatf("v%0d pc32", i), 64'(bus32.out_pc), 64'h1000 + 64'(4 * i));
      check($sformatf("v%0d valid64", i), 64'(bus64.out_valid), 64'd1);
      check($sformatf("v%0d imm64", i), bus64.out_imm, vecs[i].imm64);
      check($sformatf("v%0d fmt64", i), 64'(bus64.out_fmt), 64'(vecs[i].fmt64));
      check($sformatf("v%0d ill64", i), 64'(bus64.out_illegal), 64'(vecs[i].ill64));
      check($sformatf("v%0d pc64", i), bus64.out_pc, 64'h1000 + 64'(4 * i));
    end
    in_valid = 1'b0;
    step();
    check("drain valid32", 64'(bus32.out_valid), 64'd0);

    // Stall three cycles with input offered: two entries held, then in-order drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc     = 64'h100;
    check("stall pre in_ready32", 64'(bus32.in_ready), 64'd1);
    step();
    check("stall1 valid32", 64'(bus32.out_valid), 64'd1);
    check("stall1 imm32", 64'(bus32.out_imm), 64'd1);
    check("stall1 in_ready32", 64'(bus32.in_ready), 64'd1);
    check("stall1 noskid in_ready", 64'(bus_s0.in_ready), 64'd0);
    in_instr = 32'h00200093;
    in_pc    = 64'h104;
    step();
    check("stall2 imm32", 64'(bus32.out_imm), 64'd1);
    check("stall2 pc32", 64'(bus32.out_pc), 64'h100);
    check("stall2 in_ready32", 64'(bus32.in_ready), 64'd0);
    in_instr = 32'h00300093;
    in_pc    = 64'h108;
    step();
    check("stall3 valid32", 64'(bus32.out_valid), 64'd1);
    check("stall3 imm32", 64'(bus32.out_imm), 64'd1);
    check("stall3 in_ready32", 64'(bus32.in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("release noskid in_ready", 64'(bus_s0.in_ready), 64'd1);
    step();
    check("drain1 imm32", 64'(bus32.out_imm), 64'd2);
    check("drain1 pc32", 64'(bus32.out_pc), 64'h104);
    check("drain1 in_ready32", 64'(bus32.in_ready), 64'd1);
    step();
    check("drain2 valid32", 64'(bus32.out_valid), 64'd1);
    check("drain2 imm32", 64'(bus32.out_imm), 64'd3);
    check("drain2 pc64", bus64.out_pc, 64'h108);
    in_valid = 1'b0;
    step();
    check("drain3 valid32", 64'(bus32.out_valid), 64'd0);

    // Flush with both entries full: everything invalid, ready restored, offered input dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc     = 64'h200;
    step();
    in_instr = 32'h00200093;
    in_pc    = 64'h204;
    step();
    check("preflush in_ready32", 64'(bus32.in_ready), 64'd0);
    check("preflush valid32", 64'(bus32.out_valid), 64'd1);
    flush    = 1'b1;
    in_instr = 32'h00300093;
    in_pc    = 64'h208;
    step();
    check("flush valid32", 64'(bus32.out_valid), 64'd0);
    check("flush in_ready32", 64'(bus32.in_ready), 64'd1);
    check("flush valid64", 64'(bus64.out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    check("flush empty-accept dropped", 64'(bus32.out_valid), 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check("postflush valid32", 64'(bus32.out_valid), 64'd0);

    // Reset dropped mid-stall clears outputs without a clock edge, then normal accept.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc     = 64'h300;
    step();
    in_instr = 32'h00200093;
    in_pc    = 64'h304;
    step();
    check("prerst in_ready32", 64'(bus32.in_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst valid32", 64'(bus32.out_valid), 64'd0);
    check("midrst in_ready32", 64'(bus32.in_ready), 64'd1);
    check("midrst imm32", 64'(bus32.out_imm), 64'd0);
    check("midrst pc64", bus64.out_pc, 64'd0);
    check("midrst valid64", 64'(bus64.out_valid), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h00300093;
    in_pc     = 64'h308;
    step();
    check("postrst valid32", 64'(bus32.out_valid), 64'd1);
    check("postrst imm32", 64'(bus32.out_imm), 64'd3);
    check("postrst pc32", 64'(bus32.out_pc), 64'h308);
    in_valid = 1'b0;
    step();
    check("postrst drain valid32", 64'(bus32.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
